// File: rtl/input_periph_sampler.sv
// Memory-mapped input sampler: 2-flop synchronised switches and buttons, debounced buttons, sticky W1C press flags.
// Optional macro INPUT_PERIPH_IRQ_EN adds BTN_MASK at 0x930 and a registered irq_o.
module input_periph_sampler #(
  parameter int SW_W            = 18,
  parameter int BTN_W           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SW_W-1:0]   io_sw_i,
  input  logic [BTN_W-1:0]  io_btn_i,
  input  logic [11:0]       addr_i,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o
`ifdef INPUT_PERIPH_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [BTN_W-1:0] btn_s1_q, btn_s2_q;
  logic [BTN_W-1:0] btn_sync;
  logic [BTN_W-1:0] lvl_q, lvl_d;
  logic [BTN_W-1:0] press_q, press_d;
  logic [BTN_W-1:0] press_clr;
  logic [CW-1:0]    cnt_q [BTN_W];
  logic [CW-1:0]    cnt_d [BTN_W];
  logic [31:0]      rd_sel;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             unused_bits;

  assign unused_bits = ^{addr_i[3:0], wdata_i};
  assign btn_sync    = ~btn_s2_q;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int i = 0; i < BTN_W; i++) begin
      if (btn_sync[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        lvl_d[i] = ~lvl_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Rising edge is taken from lvl_d so a same-cycle W1C loses to the new press.
  assign press_clr = (wr_en_i && addr_i[11:4] == 8'h92) ? wdata_i[BTN_W-1:0] : '0;
  assign press_d   = (press_q & ~press_clr) | (lvl_d & ~lvl_q);

`ifdef INPUT_PERIPH_IRQ_EN
  logic [BTN_W-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  assign mask_d = (wr_en_i && addr_i[11:4] == 8'h93) ? wdata_i[BTN_W-1:0] : mask_q;
  assign irq_d  = |(press_q & mask_q);
  assign irq_o  = irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end
`endif

  // Reads see register state from before any same-cycle write or flag set.
  always_comb begin
    rd_sel = '0;
    case (addr_i[11:4])
      8'h90: rd_sel[SW_W-1:0]  = sw_s2_q;
      8'h91: rd_sel[BTN_W-1:0] = lvl_q;
      8'h92: rd_sel[BTN_W-1:0] = press_q;
`ifdef INPUT_PERIPH_IRQ_EN
      8'h93: rd_sel[BTN_W-1:0] = mask_q;
`endif
      default: ;
    endcase
  end

  assign rdata_d  = rd_en_i ? rd_sel : '0;
  assign rvalid_d = rd_en_i;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '1;
      btn_s2_q <= '1;
      lvl_q    <= '0;
      press_q  <= '0;
      for (int i = 0; i < BTN_W; i++) cnt_q[i] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      sw_s1_q  <= io_sw_i;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= io_btn_i;
      btn_s2_q <= btn_s1_q;
      lvl_q    <= lvl_d;
      press_q  <= press_d;
      for (int i = 0; i < BTN_W; i++) cnt_q[i] <= cnt_d[i];
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_input_periph_sampler.sv
// Directed bench for input_periph_sampler with DEBOUNCE_CYCLES=4.
// IRQ scenario is compiled in only when INPUT_PERIPH_IRQ_EN is defined.
module tb_input_periph_sampler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [17:0] io_sw_i;
  logic [3:0]  io_btn_i;
  logic [11:0] addr_i;
  logic        rd_en_i;
  logic        wr_en_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
`ifdef INPUT_PERIPH_IRQ_EN
  logic        irq_o;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  input_periph_sampler #(.SW_W(18), .BTN_W(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .io_sw_i  (io_sw_i),
    .io_btn_i (io_btn_i),
    .addr_i   (addr_i),
    .rd_en_i  (rd_en_i),
    .wr_en_i  (wr_en_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o)
`ifdef INPUT_PERIPH_IRQ_EN
    ,
    .irq_o    (irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic v);
    addr_i  = a;
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    d = rdata_o;
    v = rvalid_o;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] wd);
    addr_i  = a;
    wdata_i = wd;
    wr_en_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    logic [11:0] addrs [3];
    addrs[0] = 12'h900; addrs[1] = 12'h910; addrs[2] = 12'h920;
    rst_i = 1'b1;
    ticks(3);
    vec_cnt++;
    if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_out got rvalid=%b rdata=%h exp 0/0", rvalid_o, rdata_o);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, v);
      vec_cnt++;
      if (v !== 1'b1 || d !== 32'h0) begin
        err_cnt++;
        $display("FAIL reset_read_%h got v=%b d=%h exp 1/0", addrs[i], v, d);
      end
    end
    tick();
    vec_cnt++;
    if (rvalid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL rvalid_pulse got %b exp 0", rvalid_o);
    end
  endtask

  task automatic test_switch();
    logic [31:0] d;
    logic v;
    io_sw_i = 18'h2A5A5;
    tick();
    do_read(12'h900, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL sw_early got %h exp 00000000", d);
    end
    do_read(12'h900, d, v);
    vec_cnt++;
    if (v !== 1'b1 || d !== 32'h0002A5A5) begin
      err_cnt++;
      $display("FAIL sw_sync got v=%b d=%h exp 1/0002a5a5", v, d);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    logic v;
    io_btn_i = 4'b1011;
    ticks(3);
    io_btn_i = 4'hF;
    ticks(4);
    do_read(12'h910, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL glitch_lvl got %h exp 00000000", d);
    end
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL glitch_press got %h exp 00000000", d);
    end
    io_btn_i = 4'b1011;
    ticks(5);
    do_read(12'h910, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL lvl_edge5 got %h exp 00000000", d);
    end
    do_read(12'h910, d, v);
    vec_cnt++;
    if (d !== 32'h4) begin
      err_cnt++;
      $display("FAIL lvl_edge6 got %h exp 00000004", d);
    end
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h4) begin
      err_cnt++;
      $display("FAIL press_set got %h exp 00000004", d);
    end
    io_btn_i = 4'hF;
    ticks(8);
    do_read(12'h910, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL lvl_release got %h exp 00000000", d);
    end
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h4) begin
      err_cnt++;
      $display("FAIL press_sticky got %h exp 00000004", d);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    logic v;
    io_btn_i = 4'b1110;
    ticks(7);
    io_btn_i = 4'hF;
    ticks(8);
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h5) begin
      err_cnt++;
      $display("FAIL press_two got %h exp 00000005", d);
    end
    do_write(12'h920, 32'h1);
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h4) begin
      err_cnt++;
      $display("FAIL w1c_bit0 got %h exp 00000004", d);
    end
    do_write(12'h920, 32'h4);
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL w1c_bit2 got %h exp 00000000", d);
    end
    io_btn_i = 4'b1011;
    ticks(5);
    do_write(12'h920, 32'h4);
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h4) begin
      err_cnt++;
      $display("FAIL set_beats_clr got %h exp 00000004", d);
    end
    io_btn_i = 4'hF;
    ticks(8);
    do_write(12'h910, 32'hF);
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h4) begin
      err_cnt++;
      $display("FAIL wr_other_addr got %h exp 00000004", d);
    end
    addr_i  = 12'h920;
    wdata_i = 32'h4;
    rd_en_i = 1'b1;
    wr_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    wr_en_i = 1'b0;
    vec_cnt++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'h4) begin
      err_cnt++;
      $display("FAIL rd_wr_same got v=%b d=%h exp 1/00000004", rvalid_o, rdata_o);
    end
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL rd_wr_after got %h exp 00000000", d);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic v;
    do_read(12'h940, d, v);
    vec_cnt++;
    if (v !== 1'b1 || d !== 32'h0) begin
      err_cnt++;
      $display("FAIL rd_940 got v=%b d=%h exp 1/0", v, d);
    end
    do_read(12'hA00, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL rd_a00 got %h exp 00000000", d);
    end
    do_read(12'h904, d, v);
    vec_cnt++;
    if (d !== 32'h0002A5A5) begin
      err_cnt++;
      $display("FAIL rd_904 got %h exp 0002a5a5", d);
    end
`ifndef INPUT_PERIPH_IRQ_EN
    do_read(12'h930, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL rd_930 got %h exp 00000000", d);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    logic [11:0] addrs [3];
    addrs[0] = 12'h900; addrs[1] = 12'h910; addrs[2] = 12'h920;
    exp_d[0] = 32'h0002A5A5; exp_d[1] = 32'h2; exp_d[2] = 32'h2;
    io_btn_i = 4'b1101;
    ticks(8);
    rd_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr_i = addrs[i];
      tick();
      vec_cnt++;
      if (rvalid_o !== 1'b1 || rdata_o !== exp_d[i]) begin
        err_cnt++;
        $display("FAIL b2b_%0d got v=%b d=%h exp 1/%h", i, rvalid_o, rdata_o, exp_d[i]);
      end
    end
    rd_en_i = 1'b0;
    tick();
    vec_cnt++;
    if (rvalid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_end got %b exp 0", rvalid_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    io_btn_i = 4'b0101;
    ticks(4);
    addr_i  = 12'h900;
    rd_en_i = 1'b1;
    rst_i   = 1'b1;
    tick();
    rd_en_i = 1'b0;
    vec_cnt++;
    if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
      err_cnt++;
      $display("FAIL rst_rd got v=%b d=%h exp 0/0", rvalid_o, rdata_o);
    end
    io_btn_i = 4'b0111;
    tick();
    rst_i = 1'b0;
    do_read(12'h900, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL rst_sw_sync got %h exp 00000000", d);
    end
    ticks(2);
    io_btn_i = 4'hF;
    ticks(8);
    do_read(12'h910, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL rst_cnt_lvl got %h exp 00000000", d);
    end
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h0) begin
      err_cnt++;
      $display("FAIL rst_press got %h exp 00000000", d);
    end
  endtask

`ifdef INPUT_PERIPH_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    logic v;
    do_write(12'h930, 32'h2);
    do_read(12'h930, d, v);
    vec_cnt++;
    if (d !== 32'h2 || irq_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL mask_rd got d=%h irq=%b exp 00000002/0", d, irq_o);
    end
    io_btn_i = 4'b1101;
    ticks(6);
    vec_cnt++;
    if (irq_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL irq_pre got %b exp 0", irq_o);
    end
    tick();
    vec_cnt++;
    if (irq_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL irq_set got %b exp 1", irq_o);
    end
    io_btn_i = 4'hF;
    do_write(12'h920, 32'h2);
    vec_cnt++;
    if (irq_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL irq_hold got %b exp 1", irq_o);
    end
    tick();
    vec_cnt++;
    if (irq_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL irq_clr got %b exp 0", irq_o);
    end
    ticks(6);
    io_btn_i = 4'b1110;
    ticks(8);
    vec_cnt++;
    if (irq_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL irq_masked got %b exp 0", irq_o);
    end
    do_read(12'h920, d, v);
    vec_cnt++;
    if (d !== 32'h1) begin
      err_cnt++;
      $display("FAIL irq_press0 got %h exp 00000001", d);
    end
    io_btn_i = 4'hF;
    ticks(8);
  endtask
`endif

  initial begin
    rst_i    = 1'b1;
    io_sw_i  = '0;
    io_btn_i = 4'hF;
    addr_i   = '0;
    rd_en_i  = 1'b0;
    wr_en_i  = 1'b0;
    wdata_i  = '0;
    test_reset();
    test_switch();
    test_debounce();
    test_w1c();
    test_decode();
    test_back_to_back();
    test_reset_mid();
`ifdef INPUT_PERIPH_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
